// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// Every grant is followed by one idle cycle before the next grant can be issued.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [2:0] owner,
    output logic       timeout
);

    // state | meaning
    // IDLE  | no grant held; the next request found searching up from ptr wins
    // BUSY  | one requester holds the grant until done, request drop, or hold limit
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [7:0] grant_d;
    logic       grant_valid_d;
    logic [2:0] owner_d;
    logic       timeout_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;

    logic [2:0] cand;
    logic [2:0] pick_idx;
    logic       pick_found;
    logic       rel_cap, rel_drop, release_now;

    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + i[2:0];
            if (!pick_found && req[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    assign rel_cap     = (hold_q == HOLD_MAX);
    assign rel_drop    = ~req[owner];
    assign release_now = done | rel_drop | rel_cap;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant;
        grant_valid_d = grant_valid;
        owner_d       = owner;
        timeout_d     = 1'b0;
        ptr_d         = ptr_q;
        hold_d        = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d       = BUSY;
                    grant_d       = 8'b1 << pick_idx;
                    grant_valid_d = 1'b1;
                    owner_d       = pick_idx;
                    hold_d        = 4'd1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    owner_d       = '0;
                    ptr_d         = owner + 3'd1;
                    hold_d        = '0;
                    // Timeout only flags a release forced purely by the hold limit.
                    timeout_d     = rel_cap & ~done & ~rel_drop;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            owner       <= '0;
            timeout     <= 1'b0;
            ptr_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant       <= grant_d;
            grant_valid <= grant_valid_d;
            owner       <= owner_d;
            timeout     <= timeout_d;
            ptr_q       <= ptr_d;
            hold_q      <= hold_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: a cycle model pushes expected outputs to a scoreboard,
// which is popped after each clock edge, plus directed checks of known sequences.
module tb_rr_arbiter_8;

    localparam int MH = 8;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] owner;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] g;
        logic [2:0] o;
        logic       v;
        logic       t;
    } exp_t;

    exp_t sb[$];

    bit         m_busy;
    int         m_owner;
    int         m_ptr;
    int         m_hold;
    logic [7:0] m_grant;
    logic       m_to;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_valid(grant_valid),
        .owner      (owner),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [7:0] rq, input logic d);
        bit found;
        int j;
        bit cap;
        if (r) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_grant = '0; m_to = 1'b0;
        end else if (!m_busy) begin
            m_to = 1'b0;
            found = 0;
            for (int k = 0; k < 8; k++) begin
                j = (m_ptr + k) % 8;
                if (!found && rq[j]) begin
                    found   = 1;
                    m_owner = j;
                end
            end
            if (found) begin
                m_busy  = 1;
                m_hold  = 1;
                m_grant = 8'(1 << m_owner);
            end
        end else begin
            cap = (m_hold == MH);
            if (d || !rq[m_owner] || cap) begin
                m_to    = cap && !d && rq[m_owner];
                m_ptr   = (m_owner + 1) % 8;
                m_owner = 0;
                m_busy  = 0;
                m_grant = '0;
                m_hold  = 0;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] rq, input logic d);
        exp_t e;
        reset = r;
        req   = rq;
        done  = d;
        model_update(r, rq, d);
        e.g = m_grant;
        e.o = 3'(m_owner);
        e.v = (m_grant != 0);
        e.t = m_to;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("grant", grant, e.g);
        check_val("owner", owner, e.o);
        check_val("grant_valid", grant_valid, e.v);
        check_val("timeout", timeout, e.t);
        check_val("grant_onehot", ($countones(grant) <= 1), 1);
        check_val("gv_matches_grant", grant_valid, (grant != 0));
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        done  = 1'b0;

        // reset state
        step(1, 8'h00, 0);
        step(1, 8'h00, 0);
        check_val("rst_grant", grant, 0);
        check_val("rst_owner", owner, 0);
        check_val("rst_timeout", timeout, 0);

        // single requester 0
        step(0, 8'h00, 0);
        check_val("idle_noreq", grant, 0);
        step(0, 8'b0000_0001, 0);
        check_val("r27_grant", grant, 8'h01);
        check_val("r27_owner", owner, 0);
        check_val("r27_gv", grant_valid, 1);
        step(0, 8'b0000_0001, 1);
        check_val("r27_release", grant, 0);
        step(0, 8'h00, 0);

        // two requesters from ptr=0
        step(1, 8'h00, 0);
        step(0, 8'b1000_0100, 0);
        check_val("r28_first", grant, 8'b0000_0100);
        check_val("r28_owner2", owner, 2);
        step(0, 8'b1000_0100, 0);
        step(0, 8'b1000_0100, 1);
        check_val("r28_idle_gap", grant, 0);
        step(0, 8'b1000_0100, 0);
        check_val("r28_second", grant, 8'b1000_0000);
        check_val("r28_owner7", owner, 7);
        step(0, 8'b1000_0100, 1);
        step(0, 8'h00, 0);

        // all requesting, done each grant -> owners rotate with idle gaps
        step(1, 8'h00, 0);
        for (int k = 0; k < 9; k++) begin
            step(0, 8'hFF, 0);
            check_val("r29_owner", owner, k % 8);
            step(0, 8'hFF, 1);
            check_val("r29_gap", grant, 0);
        end

        // hold limit timeout and re-grant
        step(1, 8'h00, 0);
        for (int k = 0; k < MH; k++) begin
            step(0, 8'b0001_0000, 0);
            check_val("r30_held", grant, 8'b0001_0000);
        end
        step(0, 8'b0001_0000, 0);
        check_val("r30_drop", grant, 0);
        check_val("r30_timeout", timeout, 1);
        step(0, 8'b0001_0000, 0);
        check_val("r30_regrant", owner, 4);
        check_val("r30_to_clear", timeout, 0);

        // done coincides with hold limit: no timeout
        step(1, 8'h00, 0);
        for (int k = 0; k < MH; k++) step(0, 8'b0001_0000, 0);
        step(0, 8'b0001_0000, 1);
        check_val("r20_grant", grant, 0);
        check_val("r20_timeout", timeout, 0);

        // request drop releases without timeout
        step(0, 8'b0000_0010, 0);
        step(0, 8'b0000_0000, 0);
        check_val("drop_release", grant, 0);
        check_val("drop_timeout", timeout, 0);

        // reset mid-grant
        step(1, 8'h00, 0);
        step(0, 8'b0010_0000, 0);
        check_val("r31_owner5", owner, 5);
        step(1, 8'b0010_0001, 0);
        check_val("r31_rst_grant", grant, 0);
        check_val("r31_rst_owner", owner, 0);
        step(0, 8'b0010_0001, 0);
        check_val("r31_first", grant, 8'b0000_0001);

        // done while idle is ignored
        step(1, 8'h00, 0);
        step(0, 8'h00, 1);
        check_val("r21_idle", grant, 0);
        step(0, 8'b0000_1000, 1);
        check_val("r21_grant", grant, 8'b0000_1000);
        step(0, 8'b0000_1000, 1);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            logic [7:0] rq;
            rq = 8'($urandom);
            if ($urandom_range(0, 2) == 0) rq = rq & 8'($urandom);
            step(($urandom_range(0, 60) == 0), rq, ($urandom_range(0, 4) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning: maximum consecutive cycles one requester may hold a grant (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 req  input  8  request vector; bit i high = requester i wants the shared resource.
REQ-005 done  input  1  current owner releases grant; meaningful only while grant_valid=1.
REQ-006 grant  output  8  registered one-hot grant vector; feeds the downstream 8-to-3 encoder d input.
REQ-007 grant_valid  output  1  registered; high whenever grant is non-zero; drives downstream encoder enable.
REQ-008 owner  output  3  registered binary index of current grant holder; 0 when grant_valid=0.
REQ-009 timeout  output  1  registered one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-010 Two-state FSM: IDLE (no grant) and BUSY (one grant held); all outputs registered.
REQ-011 grant SHALL be all-zero or exactly one-hot at every cycle; never more than one bit set.
REQ-012 IDLE, req==0: stay IDLE, outputs unchanged at zero.
REQ-013 IDLE, req!=0: next cycle enter BUSY, grant to first set req bit searching upward from pointer ptr, wrapping 7->0; latency exactly 1 cycle from req sampled to grant visible.
REQ-014 On entering BUSY: owner=granted index, hold counter loaded to 1.
REQ-015 BUSY, release condition = done=1 OR req[owner]=0 OR hold counter==MAX_HOLD.
REQ-016 BUSY, release condition true: next cycle return to IDLE with grant=0, grant_valid=0, owner=0; ptr=(owner+1) mod 8.
REQ-017 Release always inserts one idle cycle (grant=0) before any new grant; no back-to-back grants.
REQ-018 BUSY, no release: grant held stable, hold counter increments by 1; requests from other bits ignored.
REQ-019 timeout pulses high for the single cycle grant drops only when the release was caused solely by the counter (done=0 and req[owner]=1).
REQ-020 Simultaneous done=1 and counter==MAX_HOLD: treated as normal release, timeout=0.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 ptr wraps 7 -> 0; search order from ptr=k is k, k+1, ..., 7, 0, ..., k-1.
REQ-023 Hold counter is 4 bits; it never exceeds MAX_HOLD.

Reset
REQ-024 reset=1 at a clock edge: state=IDLE, grant=0, grant_valid=0, owner=0, timeout=0, ptr=0, hold counter=0, regardless of current state.
REQ-025 Reset mid-grant SHALL drop grant on the same edge; first grant after reset release follows REQ-013 with ptr=0.
REQ-026 No output changes except on a rising clk edge; no asynchronous reset path.

Verification
REQ-027 Reset, then req=8'b0000_0001 -> one cycle later grant=8'b0000_0001, grant_valid=1, owner=0; downstream encoder y=0.
REQ-028 ptr=0, req=8'b1000_0100, done pulse after 2 cycles -> grant 0000_0100 (owner=2), one idle cycle, then grant 1000_0000 (owner=7).
REQ-029 req=8'hFF held constant, done pulsed each grant -> owners cycle 0,1,2,...,7,0, each separated by one grant=0 cycle.
REQ-030 MAX_HOLD=8, req=8'b0001_0000 held, done=0 -> grant held 8 cycles, then grant=0 with timeout=1 for one cycle, then re-grant owner=4.
REQ-031 Grant held for owner=5, reset=1 for one cycle -> next edge grant=0, owner=0; after reset with req=8'b0010_0001 -> owner=0 granted first.
REQ-032 Every cycle of every test: check grant is zero or one-hot and grant_valid==(grant!=0).
